// File: rtl/bigger.sv
// bigger: restores a halved packed complex sample to full scale.
// Input words carry two guard bits above two (WIDTH/2-1)-bit signed
// fields. Words with non-zero guard bits are dropped and flagged. Valid
// words are doubled and queued in a 2-entry FIFO with ready/valid
// handshakes on both sides.
// Optional feature: define BIGGER_ERRCNT_EN to add a saturating 16-bit
// malformed-word counter on port err_count.
module bigger #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_nd,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  input  logic             out_ready,
`ifdef BIGGER_ERRCNT_EN
  output logic             error,
  output logic [15:0]      err_count
`else
  output logic             error
`endif
);

  localparam int HW = WIDTH / 2;

  // A word is well formed only when both guard bits are clear.
  function automatic logic guard_ok(input logic [WIDTH-1:0] w);
    return (w[WIDTH-1:WIDTH-2] == 2'b00);
  endfunction

  // Each signed field is shifted left by one; the guard bits make room,
  // so the doubled value always fits and cannot overflow.
  function automatic logic [WIDTH-1:0] restore(input logic [WIDTH-1:0] w);
    return {w[WIDTH-3:HW-1], 1'b0, w[HW-2:0], 1'b0};
  endfunction

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             error_r;
  logic             out_xfer_s;
  logic             ready_s;
  logic             in_xfer_s;
  logic             push_s;
  logic             bad_s;

  // Handshake decode: a full FIFO may accept a word only when the head
  // is leaving in the same cycle; reset holds the input side closed.
  always_comb begin
    out_xfer_s = 1'b0;
    ready_s    = 1'b0;
    in_xfer_s  = 1'b0;
    push_s     = 1'b0;
    bad_s      = 1'b0;
    out_xfer_s = (count_r != 2'd0) && out_ready;
    case (count_r)
      2'd0:    ready_s = 1'b1;
      2'd1:    ready_s = 1'b1;
      2'd2:    ready_s = out_xfer_s;
      default: ready_s = 1'b0;
    endcase
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      ready_s = ready_s;
    end
    in_xfer_s = in_nd && ready_s;
    push_s    = in_xfer_s && guard_ok(in_data);
    bad_s     = in_xfer_s && !guard_ok(in_data);
  end

  // Storage: restored words are written at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= restore(in_data);
    end
  end

  // Pointers wrap modulo 2; occupancy is unchanged on a simultaneous
  // push and pop, and dropped words never touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (out_xfer_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, out_xfer_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // One-cycle pulse the cycle after a malformed word is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= bad_s;
    end
  end

`ifdef BIGGER_ERRCNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of dropped words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= 16'h0000;
    end else if (bad_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_count = err_cnt_r;
`endif

  assign in_ready = ready_s;
  assign out_nd   = (count_r != 2'd0);
  assign out_data = mem_r[rd_ptr_r];
  assign error    = error_r;

endmodule
